wash_ctrl_p: RTL and testbench

WASH_CTRL_P -- requirements
Module: wash_ctrl_p

---
 rtl/wash_ctrl_p.sv | 263 ++++++++++++++++++++++++++
 tb/tb_wash_ctrl_p.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/wash_ctrl_p.sv
// ---------------------------------------------------------------------------
// wash_ctrl_p -- washing-machine program sequencer
//
// Runs a fixed program WASH -> RINSE x RINSE_CNT -> SPIN -> DONE. Each phase
// lasts its configured number of seconds. A second is CLK_DIV enabled clock
// cycles, counted by a prescaler that only advances while a phase is running
// and 'on' is high. The remaining time of the current phase is kept directly
// as three BCD digits. The parameter values are converted to decimal at
// elaboration, so there is no run-time binary-to-BCD logic.
//
// Parameters:
//   CLK_DIV    clk cycles per one-second tick (>= 2)
//   WASH_S     wash duration, seconds (1..999)
//   RINSE_S    duration of each rinse pass, seconds (1..999)
//   RINSE_CNT  number of rinse passes (1..7)
//   SPIN_S     spin duration, seconds (1..999)
//
// Ports:
//   clk        system clock, rising edge
//   rst        synchronous active-high reset, beats every other input
//   on         run enable; low freezes a running program where it is
//   start      single-cycle request: in IDLE or DONE it begins a program,
//              while a program runs it is ignored. It is sampled on its own,
//              with no handshake back, and it does not depend on 'on'.
//   n1/n2/n3   remaining seconds, BCD units / tens / hundreds
//   state      phase code IDLE=0 WASH=1 RINSE=2 SPIN=3 DONE=4 (this is the
//              FSM state register itself)
//   rinse_idx  current rinse pass, 1-based, 0 outside RINSE
//   st_light   phase indicator lamps
//   busy       high in WASH, RINSE and SPIN
//   done       one-cycle pulse on entry to DONE
//
// All outputs come straight from flops.
// ---------------------------------------------------------------------------
module wash_ctrl_p #(
  parameter int CLK_DIV   = 100000000,
  parameter int WASH_S    = 60,
  parameter int RINSE_S   = 30,
  parameter int RINSE_CNT = 2,
  parameter int SPIN_S    = 45
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       on,
  input  logic       start,
  output logic [3:0] n1,
  output logic [3:0] n2,
  output logic [3:0] n3,
  output logic [2:0] state,
  output logic [2:0] rinse_idx,
  output logic [7:0] st_light,
  output logic       busy,
  output logic       done
);

  // -------------------------------------------------------------------------
  // Elaboration-time constants
  // -------------------------------------------------------------------------
  localparam int PW = $clog2(CLK_DIV);
  localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_DIV - 1);

  // Decimal digits of a parameter, packed as {hundreds, tens, units}.
  function automatic logic [11:0] to_bcd(input int v);
    return {4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
  endfunction

  localparam logic [11:0] WASH_BCD   = to_bcd(WASH_S);
  localparam logic [11:0] RINSE_BCD  = to_bcd(RINSE_S);
  localparam logic [11:0] SPIN_BCD   = to_bcd(SPIN_S);
  localparam logic [2:0]  RINSE_LAST = 3'(RINSE_CNT);
  localparam logic [11:0] BCD_ONE    = 12'h001;

  localparam logic [7:0] LIGHT_IDLE  = 8'b0000_0000;
  localparam logic [7:0] LIGHT_WASH  = 8'b0000_1111;
  localparam logic [7:0] LIGHT_RINSE = 8'b0011_1111;
  localparam logic [7:0] LIGHT_SPIN  = 8'b0111_1111;
  localparam logic [7:0] LIGHT_DONE  = 8'b1111_1111;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WASH  = 3'd1,
    S_RINSE = 3'd2,
    S_SPIN  = 3'd3,
    S_DONE  = 3'd4
  } phase_e;

  // Decrement a three-digit BCD value by one. Callers never pass 000,
  // because a phase is left on the tick that finds 001.
  function automatic logic [11:0] bcd_dec(input logic [11:0] v);
    logic [3:0] d0;
    logic [3:0] d1;
    logic [3:0] d2;
    d0 = v[3:0];
    d1 = v[7:4];
    d2 = v[11:8];
    if (d0 != 4'd0) begin
      d0 = d0 - 4'd1;
    end else begin
      d0 = 4'd9;
      if (d1 != 4'd0) begin
        d1 = d1 - 4'd1;
      end else begin
        d1 = 4'd9;
        d2 = d2 - 4'd1;
      end
    end
    return {d2, d1, d0};
  endfunction

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  phase_e          state_q, state_d;
  logic [11:0]     cnt_q, cnt_d;      // remaining seconds, BCD
  logic [2:0]      idx_q, idx_d;      // rinse pass
  logic [PW-1:0]   presc_q, presc_d;
  logic [7:0]      light_q, light_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;

  logic            running;
  logic            tick;

  assign running = (state_q == S_WASH) || (state_q == S_RINSE) ||
                   (state_q == S_SPIN);
  assign tick    = running && on && (presc_q == PRESC_MAX);

  // -------------------------------------------------------------------------
  // Process 1: state register (also holds the registered outputs)
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 12'h000;
      idx_q   <= 3'd0;
      presc_q <= '0;
      light_q <= LIGHT_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      presc_q <= presc_d;
      light_q <= light_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // -------------------------------------------------------------------------
  // Process 2: next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    presc_d = presc_q;

    unique case (state_q)
      S_IDLE, S_DONE: begin
        // 'on' is deliberately not consulted here.
        if (start) begin
          state_d = S_WASH;
          cnt_d   = WASH_BCD;
          idx_d   = 3'd0;
          presc_d = '0;
        end
      end

      S_WASH, S_RINSE, S_SPIN: begin
        // With on=0 nothing moves, so resuming picks up the exact cycle.
        if (on) begin
          if (!tick) begin
            presc_d = presc_q + 1'b1;
          end else if (cnt_q != BCD_ONE) begin
            presc_d = '0;
            cnt_d   = bcd_dec(cnt_q);
          end else begin
            // Last second of the phase has elapsed: the next phase and its
            // duration are loaded on this same edge, so no cycle is lost.
            presc_d = '0;
            unique case (state_q)
              S_WASH: begin
                state_d = S_RINSE;
                idx_d   = 3'd1;
                cnt_d   = RINSE_BCD;
              end
              S_RINSE: begin
                if (idx_q < RINSE_LAST) begin
                  idx_d = idx_q + 3'd1;
                  cnt_d = RINSE_BCD;
                end else begin
                  state_d = S_SPIN;
                  idx_d   = 3'd0;
                  cnt_d   = SPIN_BCD;
                end
              end
              default: begin
                state_d = S_DONE;
                idx_d   = 3'd0;
                cnt_d   = 12'h000;
              end
            endcase
          end
        end
      end

      default: begin
        // Unused encodings recover to a clean IDLE.
        state_d = S_IDLE;
        cnt_d   = 12'h000;
        idx_d   = 3'd0;
        presc_d = '0;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Process 3: output logic, computed from the next state so the outputs
  // can be registered alongside the state itself
  // -------------------------------------------------------------------------
  always_comb begin
    light_d = LIGHT_IDLE;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    unique case (state_d)
      S_WASH: begin
        light_d = LIGHT_WASH;
        busy_d  = 1'b1;
      end
      S_RINSE: begin
        light_d = LIGHT_RINSE;
        busy_d  = 1'b1;
      end
      S_SPIN: begin
        light_d = LIGHT_SPIN;
        busy_d  = 1'b1;
      end
      S_DONE: begin
        light_d = LIGHT_DONE;
        // Only the SPIN -> DONE edge pulses; sitting in DONE does not.
        done_d  = (state_q == S_SPIN);
      end
      default: begin
        light_d = LIGHT_IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Output mapping
  // -------------------------------------------------------------------------
  assign state     = state_q;
  assign n1        = cnt_q[3:0];
  assign n2        = cnt_q[7:4];
  assign n3        = cnt_q[11:8];
  assign rinse_idx = idx_q;
  assign st_light  = light_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_wash_ctrl_p.sv
// ---------------------------------------------------------------------------
// tb_wash_ctrl_p -- self-checking bench for wash_ctrl_p
//
// A reference model tracks only "enabled cycles elapsed since start" and
// derives the phase, rinse pass and remaining seconds from that number with
// plain arithmetic. A compare process checks every output against it on
// every falling edge. Directed checks with hand-written literals pin the
// model: phase lengths, the SPIN BCD borrow sequence, pause, restart and
// reset.
// ---------------------------------------------------------------------------
module tb_wash_ctrl_p;

  localparam int CLK_DIV   = 4;
  localparam int WASH_S    = 3;
  localparam int RINSE_S   = 2;
  localparam int RINSE_CNT = 2;
  localparam int SPIN_S    = 12;
  localparam int TOTAL     = (WASH_S + RINSE_CNT * RINSE_S + SPIN_S) * CLK_DIV;

  // ---------------- clock / reset / DUT ----------------
  logic       clk;
  logic       rst;
  logic       on;
  logic       start;
  logic [3:0] n1, n2, n3;
  logic [2:0] state, rinse_idx;
  logic [7:0] st_light;
  logic       busy, done;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  wash_ctrl_p #(
    .CLK_DIV  (CLK_DIV),
    .WASH_S   (WASH_S),
    .RINSE_S  (RINSE_S),
    .RINSE_CNT(RINSE_CNT),
    .SPIN_S   (SPIN_S)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .on       (on),
    .start    (start),
    .n1       (n1),
    .n2       (n2),
    .n3       (n3),
    .state    (state),
    .rinse_idx(rinse_idx),
    .st_light (st_light),
    .busy     (busy),
    .done     (done)
  );

  // {state, rinse_idx, n3, n2, n1, st_light, busy, done}
  logic [27:0] dut_vec;
  assign dut_vec = {state, rinse_idx, n3, n2, n1, st_light, busy, done};

  localparam logic [27:0] VEC_ZERO = 28'h0;
  localparam logic [27:0] VEC_WASH3 = {3'd1, 3'd0, 12'h003, 8'h0F, 1'b1, 1'b0};

  // ---------------- check bookkeeping ----------------
  int pass_cnt = 0;
  int total_cnt = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%h, expected 0x%h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  // mode: 0 idle, 1 running, 2 done
  int model_mode = 0;
  int model_el = 0;
  bit model_done_p = 1'b0;
  bit model_valid = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      model_valid  = 1'b1;
      model_mode   = 0;
      model_el     = 0;
      model_done_p = 1'b0;
    end else begin
      model_done_p = 1'b0;
      if (model_mode != 1 && start) begin
        model_mode = 1;
        model_el   = 0;
      end else if (model_mode == 1 && on) begin
        model_el++;
        if (model_el == TOTAL) begin
          model_mode   = 2;
          model_done_p = 1'b1;
        end
      end
    end
  end

  function automatic logic [11:0] dec3(input int v);
    return {4'(v / 100), 4'(v / 10 % 10), 4'(v % 10)};
  endfunction

  function automatic logic [27:0] model_vec();
    int e;
    int ph;
    int idx;
    int rem;
    logic [7:0] lt;
    if (model_mode == 0) return VEC_ZERO;
    if (model_mode == 2) return {3'd4, 3'd0, 12'h000, 8'hFF, 1'b0, model_done_p};
    e = model_el;
    idx = 0;
    if (e < WASH_S * CLK_DIV) begin
      ph = 1; rem = WASH_S - e / CLK_DIV; lt = 8'h0F;
    end else if (e - WASH_S * CLK_DIV < RINSE_CNT * RINSE_S * CLK_DIV) begin
      e = e - WASH_S * CLK_DIV;
      ph = 2; lt = 8'h3F;
      idx = e / (RINSE_S * CLK_DIV) + 1;
      rem = RINSE_S - (e % (RINSE_S * CLK_DIV)) / CLK_DIV;
    end else begin
      e = e - (WASH_S + RINSE_CNT * RINSE_S) * CLK_DIV;
      ph = 3; lt = 8'h7F;
      rem = SPIN_S - e / CLK_DIV;
    end
    return {3'(ph), 3'(idx), dec3(rem), lt, 1'b1, 1'b0};
  endfunction

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (model_valid) check("cycle", {4'h0, dut_vec}, {4'h0, model_vec()});
  end

  // ---------------- SPIN digit sequence monitor ----------------
  bit collect = 1'b0;
  logic [11:0] seen_q[$];
  logic [11:0] exp_q[$];

  always @(negedge clk) begin
    if (collect && state == 3'd3) begin
      if (seen_q.size() == 0 || seen_q[$] != {n3, n2, n1})
        seen_q.push_back({n3, n2, n1});
    end
  end

  // ---------------- driver tasks ----------------
  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Counts falling edges spent in the given (state, rinse_idx), bounded.
  task automatic wait_phase(input logic [2:0] st, input logic [2:0] ix,
                            output int n);
    n = 0;
    while (state == st && rinse_idx == ix && n < 500) begin
      n++;
      @(negedge clk);
    end
  endtask

  // ---------------- directed sequence ----------------
  logic [27:0] snap;

  initial begin
    int n;
    int k;
    logic [11:0] spin_tab [12];
    spin_tab = '{12'h012, 12'h011, 12'h010, 12'h009, 12'h008, 12'h007,
                 12'h006, 12'h005, 12'h004, 12'h003, 12'h002, 12'h001};
    for (int i = 0; i < 12; i++) exp_q.push_back(spin_tab[i]);

    rst = 1'b1; on = 1'b0; start = 1'b0;
    repeat (3) @(negedge clk);
    check("reset", {4'h0, dut_vec}, {4'h0, VEC_ZERO});
    rst = 1'b0;
    @(negedge clk);
    check("idle_after_rst", {4'h0, dut_vec}, {4'h0, VEC_ZERO});

    // Full program with on held high.
    on = 1'b1;
    pulse_start();
    check("start_wash", {4'h0, dut_vec}, {4'h0, VEC_WASH3});
    collect = 1'b1;
    wait_phase(3'd1, 3'd0, n); check("wash_len", n, 12);
    wait_phase(3'd2, 3'd1, n); check("rinse1_len", n, 8);
    wait_phase(3'd2, 3'd2, n); check("rinse2_len", n, 8);
    wait_phase(3'd3, 3'd0, n); check("spin_len", n, 48);
    collect = 1'b0;
    check("done_entry", {4'h0, dut_vec},
          {4'h0, 3'd4, 3'd0, 12'h000, 8'hFF, 1'b0, 1'b1});
    @(negedge clk);
    check("done_pulse_end", {4'h0, dut_vec},
          {4'h0, 3'd4, 3'd0, 12'h000, 8'hFF, 1'b0, 1'b0});
    on = 1'b0;
    repeat (3) @(negedge clk);
    check("done_persist", state, 3'd4);

    check("spin_steps", seen_q.size(), exp_q.size());
    for (int i = 0; i < 12; i++) begin
      if (i < seen_q.size()) check("spin_digit", seen_q[i], exp_q[i]);
      else check("spin_digit_missing", i, 12);
    end

    // Restart from DONE with on low: start does not depend on on.
    pulse_start();
    check("restart", {4'h0, dut_vec}, {4'h0, VEC_WASH3});

    // Pause mid-WASH for 10 cycles.
    on = 1'b1;
    repeat (5) @(negedge clk);
    on = 1'b0;
    snap = dut_vec;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("pause_frozen", {4'h0, dut_vec}, {4'h0, snap});
    end
    on = 1'b1;
    @(negedge clk);
    wait_phase(3'd1, 3'd0, n);
    check("wash_len_paused", 16 + n, 22);
    check("rinse_after_pause", {rinse_idx, state}, {3'd1, 3'd2});

    // start during RINSE is ignored (the per-cycle compare covers it).
    pulse_start();
    check("rinse_ignores_start", state, 3'd2);

    // Reset in the middle of SPIN with start and on high.
    k = 0;
    while (state != 3'd3 && k < 300) begin
      @(negedge clk);
      k++;
    end
    check("reach_spin", state, 3'd3);
    repeat (9) @(negedge clk);
    rst = 1'b1; start = 1'b1;
    @(negedge clk);
    check("mid_spin_rst", {4'h0, dut_vec}, {4'h0, VEC_ZERO});
    rst = 1'b0; start = 1'b0;
    repeat (5) @(negedge clk);
    check("idle_hold", {4'h0, dut_vec}, {4'h0, VEC_ZERO});
    pulse_start();
    check("post_rst_start", {4'h0, dut_vec}, {4'h0, VEC_WASH3});
    repeat (3) @(negedge clk);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
